// File: rtl/servo_pkg.sv
// Shared servo definitions: default pulse geometry, datapath widths and the
// decoder FSM state encoding.
package servo_pkg;

  localparam int unsigned MIN_DC_DEF    = 25_000;
  localparam int unsigned MAX_DC_DEF    = 125_000;
  localparam int unsigned ANGLE_MAX_DEF = 90;
  localparam int unsigned TIMEOUT_DEF   = 2_000_000;

  localparam int ANGLE_W = 16;
  localparam int HIGH_W  = 20;
  localparam int TMO_W   = 22;

  typedef enum logic [2:0] {
    ST_ARM,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_COMPUTE,
    ST_DONE
  } dec_state_e;

  function automatic logic [31:0] clamp_u32(input logic [31:0] v,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
    logic [31:0] r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/pwm_angle_decoder_if.sv
// Signal bundle between the PWM angle decoder and its consumer.
interface pwm_angle_decoder_if;
  import servo_pkg::*;

  logic                pwm_in;
  logic [ANGLE_W-1:0]  absolute_angle;
  logic                is_negative;
  logic [HIGH_W-1:0]   high_cycles;
  logic                angle_valid;
  logic                signal_lost;
  logic                pulse_error;

  modport master (
    input  pwm_in,
    output absolute_angle, is_negative, high_cycles,
    output angle_valid, signal_lost, pulse_error
  );

  modport slave (
    output pwm_in,
    input  absolute_angle, is_negative, high_cycles,
    input  angle_valid, signal_lost, pulse_error
  );

endinterface

// File: rtl/seq_divider.sv
// 32-bit restoring divider, one quotient bit per cycle; done pulses exactly
// 32 cycles after start. The first bit is resolved on the start edge itself.
module seq_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic        done
);

  logic [31:0] rem_q, rem_d, rem_in;
  logic [31:0] quo_q, quo_d, quo_in;
  logic [32:0] shifted;
  logic [4:0]  cnt_q;
  logic        busy_q;

  always_comb begin
    rem_in  = start ? 32'd0 : rem_q;
    quo_in  = start ? dividend : quo_q;
    shifted = {rem_in, quo_in[31]};
    rem_d   = shifted[31:0];
    quo_d   = {quo_in[30:0], 1'b0};
    if (shifted >= {1'b0, divisor}) begin
      rem_d = 32'(shifted - {1'b0, divisor});
      quo_d = {quo_in[30:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q  <= rem_d;
        quo_q  <= quo_d;
        cnt_q  <= 5'd31;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        cnt_q <= cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          busy_q <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/pwm_angle_decoder.sv
// Measures servo PWM high time and converts it to a signed-magnitude angle.
//   state      | meaning
//   ARM        | after reset, wait for a low input so a partial pulse is skipped
//   WAIT_RISE  | idle, waiting for the next synchronized rising edge
//   MEASURE    | counting high cycles until the falling edge
//   COMPUTE    | clamp, centre and divide the latched high time
//   DONE       | one cycle: angle outputs updated, angle_valid high
module pwm_angle_decoder
  import servo_pkg::*;
#(
  parameter int unsigned MIN_DC         = MIN_DC_DEF,
  parameter int unsigned MAX_DC         = MAX_DC_DEF,
  parameter int unsigned ANGLE_MAX      = ANGLE_MAX_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input logic             clk,
  input logic             rst_a_n,
  pwm_angle_decoder_if.master bus
);

  localparam logic [31:0] MIN_W      = 32'(MIN_DC);
  localparam logic [31:0] MAX_W      = 32'(MAX_DC);
  localparam logic [31:0] CENTER     = 32'((MIN_DC + MAX_DC) / 2);
  localparam logic [31:0] HALF       = 32'((MAX_DC - MIN_DC) / 2);
  localparam logic [31:0] ANGLE_W32  = 32'(ANGLE_MAX);
  localparam logic [HIGH_W-1:0] GLITCH_MIN = HIGH_W'(MIN_DC / 2);
  localparam logic [HIGH_W-1:0] OVER_MAX   = HIGH_W'(2 * MAX_DC);
  localparam logic [HIGH_W-1:0] HIGH_SAT   = '1;
  localparam logic [TMO_W-1:0]  TMO_LIMIT  = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_SAT    = '1;

  dec_state_e state_q, state_d;

  logic sync1, pwm_s, pwm_prev;
  logic rise, fall;
  logic [HIGH_W-1:0] high_cnt, h_q;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic pulse_ok, pulse_bad, div_start_q, div_done;
  logic [31:0] h32, hc, diff, numer, quotient;
  logic sign;

  logic [ANGLE_W-1:0] angle_q;
  logic               neg_q, lost_q, err_q;
  logic [HIGH_W-1:0]  high_q;

  // Synchronizer and edge history reset high: a pin that is already high at
  // reset release then looks like a continuing pulse, never a rising edge.
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      sync1    <= 1'b1;
      pwm_s    <= 1'b1;
      pwm_prev <= 1'b1;
    end else begin
      sync1    <= bus.pwm_in;
      pwm_s    <= sync1;
      pwm_prev <= pwm_s;
    end
  end

  assign rise = pwm_s & ~pwm_prev;
  assign fall = ~pwm_s & pwm_prev;

  always_comb begin
    state_d   = state_q;
    pulse_ok  = 1'b0;
    pulse_bad = 1'b0;
    unique case (state_q)
      ST_ARM:       if (!pwm_s) state_d = ST_WAIT_RISE;
      ST_WAIT_RISE: if (rise) state_d = ST_MEASURE;
      ST_MEASURE: begin
        if (fall) begin
          if (high_cnt < GLITCH_MIN || high_cnt > OVER_MAX) begin
            pulse_bad = 1'b1;
            state_d   = ST_WAIT_RISE;
          end else begin
            pulse_ok = 1'b1;
            state_d  = ST_COMPUTE;
          end
        end
      end
      ST_COMPUTE: begin
        if (fall) pulse_bad = 1'b1;
        if (div_done) state_d = ST_DONE;
      end
      ST_DONE:      state_d = ST_WAIT_RISE;
      default:      state_d = ST_ARM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) state_q <= ST_ARM;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      high_cnt    <= '0;
      h_q         <= '0;
      div_start_q <= 1'b0;
    end else begin
      div_start_q <= pulse_ok;
      if (state_q == ST_WAIT_RISE && rise) high_cnt <= HIGH_W'(1);
      else if (state_q == ST_MEASURE && pwm_s && high_cnt != HIGH_SAT)
        high_cnt <= high_cnt + HIGH_W'(1);
      if (pulse_ok) h_q <= high_cnt;
    end
  end

  always_comb begin
    h32   = {{(32-HIGH_W){1'b0}}, h_q};
    hc    = clamp_u32(h32, MIN_W, MAX_W);
    sign  = hc < CENTER;
    diff  = sign ? (CENTER - hc) : (hc - CENTER);
    numer = diff * ANGLE_W32;
  end

  seq_divider u_div (
    .clk      (clk),
    .rst_n    (rst_a_n),
    .start    (div_start_q),
    .dividend (numer),
    .divisor  (HALF),
    .quotient (quotient),
    .done     (div_done)
  );

  // The rise is seen one cycle after pwm_s goes high, so that cycle already counts.
  always_comb begin
    tmo_d = tmo_q;
    if (rise)                tmo_d = TMO_W'(1);
    else if (tmo_q != TMO_SAT) tmo_d = tmo_q + TMO_W'(1);
  end

  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      tmo_q   <= '0;
      lost_q  <= 1'b1;
      err_q   <= 1'b0;
      angle_q <= '0;
      neg_q   <= 1'b0;
      high_q  <= '0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= pulse_bad;
      if (state_q == ST_COMPUTE && div_done) begin
        angle_q <= quotient[ANGLE_W-1:0];
        neg_q   <= sign && (quotient != 32'd0);
        high_q  <= h_q;
        lost_q  <= 1'b0;
      end else if (tmo_d == TMO_LIMIT) begin
        lost_q <= 1'b1;
      end
    end
  end

  assign bus.absolute_angle = angle_q;
  assign bus.is_negative    = neg_q;
  assign bus.high_cycles    = high_q;
  assign bus.angle_valid    = (state_q == ST_DONE);
  assign bus.signal_lost    = lost_q;
  assign bus.pulse_error    = err_q;

endmodule

// File: tb/tb_pwm_angle_decoder.sv
// Directed bench for pwm_angle_decoder using a scaled pulse geometry
// (MIN 250, MAX 1250, timeout 20000) so every scenario runs in few cycles.
module tb_pwm_angle_decoder;

  localparam int MIN_DC  = 250;
  localparam int MAX_DC  = 1250;
  localparam int ANG_MAX = 90;
  localparam int TMO     = 20000;

  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_valid  = 0;

  pwm_angle_decoder_if bus();

  pwm_angle_decoder #(
    .MIN_DC(MIN_DC), .MAX_DC(MAX_DC), .ANGLE_MAX(ANG_MAX), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_a_n(rst_a_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.angle_valid === 1'b1) n_valid++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " angle"}, 32'(bus.absolute_angle), 0);
    chk({tag, " neg"},   32'(bus.is_negative), 0);
    chk({tag, " high"},  32'(bus.high_cycles), 0);
    chk({tag, " valid"}, 32'(bus.angle_valid), 0);
    chk({tag, " err"},   32'(bus.pulse_error), 0);
    chk({tag, " lost"},  32'(bus.signal_lost), 1);
  endtask

  // Called #1 after an edge; pin is high for exactly h sampling edges.
  task automatic drive_pulse(input int h);
    bus.pwm_in = 1'b1;
    repeat (h) @(posedge clk);
    #1;
    bus.pwm_in = 1'b0;
  endtask

  task automatic check_decode(input string tag, input int ang, input int neg,
                              input int h, output int lat);
    lat = 0;
    while (bus.angle_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 36);
    chk({tag, " angle"},   32'(bus.absolute_angle), 32'(ang));
    chk({tag, " neg"},     32'(bus.is_negative), 32'(neg));
    chk({tag, " high"},    32'(bus.high_cycles), 32'(h));
  endtask

  task automatic pulse_ok(input string tag, input int h, input int ang, input int neg);
    int lat;
    drive_pulse(h);
    check_decode(tag, ang, neg, h, lat);
    step(1000);
  endtask

  task automatic pulse_reject(input string tag, input int h,
                              input int ang, input int neg, input int hold_h);
    int nv;
    nv = n_valid;
    drive_pulse(h);
    step(2);
    chk({tag, " err early"}, 32'(bus.pulse_error), 0);
    step(1);
    chk({tag, " err strobe"}, 32'(bus.pulse_error), 1);
    step(1);
    chk({tag, " err clear"}, 32'(bus.pulse_error), 0);
    step(50);
    chk({tag, " no valid"}, 32'(n_valid), 32'(nv));
    chk({tag, " angle hold"}, 32'(bus.absolute_angle), 32'(ang));
    chk({tag, " neg hold"}, 32'(bus.is_negative), 32'(neg));
    chk({tag, " high hold"}, 32'(bus.high_cycles), 32'(hold_h));
    step(1000);
  endtask

  initial begin
    int lat;
    int nv;
    bus.pwm_in = 1'b0;
    rst_a_n = 1'b0;
    step(5);
    chk_reset("reset");
    rst_a_n = 1'b1;
    step(20);

    drive_pulse(750);
    check_decode("center", 0, 0, 750, lat);
    chk("center lost", 32'(bus.signal_lost), 0);
    step(1000);

    pulse_ok("max", 1250, 90, 0);
    pulse_ok("min", 250, 90, 1);
    pulse_ok("mid pos", 1000, 45, 0);
    pulse_ok("mid neg", 501, 44, 1);
    pulse_ok("over clamp", 1300, 90, 0);
    pulse_reject("glitch", 124, 90, 0, 1300);
    pulse_reject("too long", 2501, 90, 0, 1300);
    pulse_ok("glitch edge", 125, 90, 1);
    pulse_ok("long edge", 2500, 90, 0);

    // Timeout: pin rises just after edge P; lost should appear after edge P+TMO+2.
    drive_pulse(1000);
    check_decode("pre tmo", 45, 0, 1000, lat);
    step(TMO + 1 - 1000 - lat);
    chk("lost before", 32'(bus.signal_lost), 0);
    step(1);
    chk("lost at limit", 32'(bus.signal_lost), 1);
    chk("lost angle hold", 32'(bus.absolute_angle), 45);
    chk("lost high hold", 32'(bus.high_cycles), 1000);
    step(500);
    drive_pulse(1250);
    chk("lost until done", 32'(bus.signal_lost), 1);
    check_decode("recover", 90, 0, 1250, lat);
    chk("lost cleared", 32'(bus.signal_lost), 0);
    step(1000);

    // Reset released with the pin already high: the partial pulse is ignored.
    rst_a_n = 1'b0;
    bus.pwm_in = 1'b1;
    step(3);
    chk_reset("rst pin high");
    nv = n_valid;
    rst_a_n = 1'b1;
    step(300);
    bus.pwm_in = 1'b0;
    step(60);
    chk("partial no valid", 32'(n_valid), 32'(nv));
    chk("partial high", 32'(bus.high_cycles), 0);
    step(500);
    pulse_ok("after partial", 1000, 45, 0);

    // Reset in the middle of MEASURE.
    bus.pwm_in = 1'b1;
    step(500);
    rst_a_n = 1'b0;
    step(1);
    chk_reset("rst measure");
    nv = n_valid;
    rst_a_n = 1'b1;
    step(400);
    bus.pwm_in = 1'b0;
    step(60);
    chk("measure no valid", 32'(n_valid), 32'(nv));
    step(500);
    pulse_ok("after measure rst", 501, 44, 1);

    // Reset in the middle of COMPUTE.
    drive_pulse(1250);
    step(20);
    rst_a_n = 1'b0;
    step(1);
    chk_reset("rst compute");
    nv = n_valid;
    rst_a_n = 1'b1;
    step(60);
    chk("compute no valid", 32'(n_valid), 32'(nv));
    step(500);
    pulse_ok("final", 250, 90, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_angle_decoder.md
# pwm_angle_decoder

Measures the high time of an incoming hobby-servo PWM signal and converts it back into the signed-magnitude angle format (`absolute_angle` plus `is_negative`) that `pwm_controller` consumes. It is the receive-side inverse of `pwm_controller`. It is used for loopback self-test of the servo outputs on GPIO and to capture an external RC receiver as an angle source for the arm's mode multiplexer.

## Interface
- `MIN_DC`, 25_000: high time in clk cycles that maps to −ANGLE_MAX.
- `MAX_DC`, 125_000: high time in clk cycles that maps to +ANGLE_MAX.
- `ANGLE_MAX`, 90: full-scale angle magnitude.
- `TIMEOUT_CYCLES`, 2_000_000: maximum number of cycles allowed between rising edges before the signal is declared lost.
- `clk` in 1: system clock, 50 MHz. This is the only clock in the block.
- `rst_a_n` in 1: asynchronous, active-low reset.
- `pwm_in` in 1: asynchronous PWM input.
- `absolute_angle` out 16: decoded angle magnitude.
- `is_negative` out 1: sign of the decoded angle.
- `high_cycles` out 20: raw high time of the last accepted pulse.
- `angle_valid` out 1: one-cycle strobe; all three outputs above update in the same cycle.
- `signal_lost` out 1: level; 1 when no valid pulse has been seen within the timeout window.
- `pulse_error` out 1: one-cycle strobe on a rejected pulse.

## Operation
- `pwm_in` passes through a 2-FF synchronizer to give `pwm_s`. Edge detection is done on `pwm_s` against its previous value.
- Derived constants:
  - CENTER = (MIN_DC+MAX_DC)/2
  - HALF = (MAX_DC−MIN_DC)/2
  - GLITCH_MIN = MIN_DC/2
  - OVER_MAX = 2·MAX_DC
- FSM states:
  - ARM: after reset, wait for `pwm_s`=0. A pulse that is already high at reset release is never measured.
  - WAIT_RISE: go to MEASURE on a rising edge. The high counter loads 1.
  - MEASURE: the counter increments while `pwm_s`=1 and saturates at 2^20−1. On a falling edge, latch the count h.
    - If h < GLITCH_MIN or h > OVER_MAX: pulse `pulse_error` and return to WAIT_RISE.
    - Otherwise go to COMPUTE.
  - COMPUTE: clamp h to [MIN_DC, MAX_DC] to give hc.
    - sign = (hc < CENTER).
    - diff = |hc − CENTER|.
    - Start the divider with numerator diff·ANGLE_MAX (32-bit) and divisor HALF.
    - Go to DONE when the divider reports done.
  - DONE: register quotient[15:0] to `absolute_angle`, sign to `is_negative`, and h to `high_cycles`. Pulse `angle_valid`, then go to WAIT_RISE.
- Arithmetic rules:
  - All products and differences are 32-bit unsigned.
  - The quotient is truncated (floor).
  - When the angle is 0, `is_negative` = 0.
- Timeout:
  - A 22-bit counter clears on every rising edge of `pwm_s` and saturates.
  - Reaching TIMEOUT_CYCLES sets `signal_lost`=1.
  - The next accepted pulse (at DONE) clears `signal_lost`.
  - Angle outputs hold their last values while the signal is lost.
- A falling edge during COMPUTE is unreachable for any legal PWM period. If it occurs, that pulse is discarded with `pulse_error`; the computation in progress completes normally.
- Reset asserted at any time returns all state and counters to reset values immediately. The FSM goes to ARM.

## Timing
- Reset values:
  - `absolute_angle`=0, `is_negative`=0, `high_cycles`=0
  - `angle_valid`=0, `pulse_error`=0
  - `signal_lost`=1
- Synchronizer latency: 2 cycles, identical on both edges, so h equals the pin high time in clk cycles exactly.
- Falling edge at the pin to `angle_valid`: exactly 36 cycles.
  - 2 cycles synchronizer.
  - 1 cycle edge detect/latch.
  - 1 cycle COMPUTE setup.
  - 32 cycles divider.
- `pulse_error` asserts 3 cycles after the pin falling edge.
- Outputs are stable between `angle_valid` strobes.
- `signal_lost` asserts TIMEOUT_CYCLES cycles after the last synchronized rising edge.

## Structure
- Shared package `servo_pkg`:
  - Default MIN_DC/MAX_DC/ANGLE_MAX.
  - Angle width (16).
  - The FSM state enum.
  - These are also used by `pwm_controller` and `angle_pwm`.
- Sub-module `seq_divider`:
  - 32-bit restoring divider, 1 quotient bit per cycle.
  - Ports: `start`, `dividend`, `divisor`, `quotient`, `done`.
  - Fixed 32-cycle latency.

## Test plan
- High 75_000 cycles, period 1_000_000 → `absolute_angle`=0, `is_negative`=0, `high_cycles`=75_000, `angle_valid` 36 cycles after the falling edge.
- High times 125_000 / 25_000 / 100_000 / 50_001 → 90/0, 90/1, 45/0, 44/1.
- High 130_000 → clamped to 90/0 with `high_cycles`=130_000. High 10_000 → `pulse_error` strobe, no `angle_valid`, outputs unchanged.
- Stop pulses after one valid pulse → `signal_lost` rises exactly 2_000_000 cycles after the last rise, angle holds. The next valid pulse clears it at its `angle_valid`.
- `pwm_in` high when reset releases → the first partial pulse is ignored; the first complete pulse decodes correctly.
- Assert `rst_a_n`=0 mid-MEASURE and mid-COMPUTE → all outputs return to reset values; no `angle_valid` until a full new pulse completes.
